data_mem_unit: RTL and testbench

//  Data-side memory that services the processor's MemRead/MemWrite requests on

---
 rtl/data_mem_unit.sv | 165 ++++++++++++++++
 tb/tb_data_mem_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Data-side memory for RV32I loads/stores: byte/half/word lanes, sign/zero
// extension, alignment/range/funct3 checks and a fixed access latency.
module data_mem_unit #(
   parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] dAddress,
   input  logic [31:0] dWriteData,
   input  logic [2:0]  funct3,
   output logic [31:0] dReadData,
   output logic        mem_ready,
   output logic        mem_err
);

   localparam int unsigned DEPTH       = 1 << ADDR_WIDTH;
   localparam logic [31:0] RANGE_BYTES = 32'(DEPTH * 4);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [1:0]            lane_q, lane_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [2:0]            f3_q, f3_d;
   logic                  store_q, store_d;
   logic                  err_q, err_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [31:0]           mem_q [DEPTH];

   logic [31:0] off;
   logic        req, bad_f3, misalign, req_err;
   logic [31:0] word, shifted, load_val, wlanes;
   logic [3:0]  be;

   // Request decode; offset uses 32-bit wrap so addresses below BASE fail the range test.
   always_comb begin
      off      = dAddress - BASE_ADDR;
      req      = MemRead | MemWrite;
      bad_f3   = 1'b0;
      misalign = 1'b0;
      case (funct3)
         3'b000:          ;
         3'b001:          misalign = dAddress[0];
         3'b010:          misalign = |dAddress[1:0];
         3'b100:          bad_f3   = MemWrite;
         3'b101: begin
            bad_f3   = MemWrite;
            misalign = dAddress[0];
         end
         default:         bad_f3   = 1'b1;
      endcase
      req_err = (MemRead & MemWrite) | bad_f3 | misalign | (off >= RANGE_BYTES);
   end

   always_comb begin
      word    = mem_q[idx_q];
      shifted = word >> {lane_q, 3'b000};
      case (f3_q)
         3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_val = {24'b0, shifted[7:0]};
         3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_val = {16'b0, shifted[15:0]};
         default: load_val = word;
      endcase
   end

   always_comb begin
      be     = '0;
      wlanes = wdata_q;
      if (state_q == DONE && store_q && !err_q) begin
         case (f3_q[1:0])
            2'b00: begin
               be     = 4'b0001 << lane_q;
               wlanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
               be     = lane_q[1] ? 4'b1100 : 4'b0011;
               wlanes = {2{wdata_q[15:0]}};
            end
            default: be = '1;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      lane_d  = lane_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      store_d = store_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = ACCESS;
               cnt_d   = 4'(LATENCY - 1);
               idx_d   = off[ADDR_WIDTH+1:2];
               lane_d  = dAddress[1:0];
               wdata_d = dWriteData;
               f3_d    = funct3;
               store_d = MemWrite;
               err_d   = req_err;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               if (err_q)         rdata_d = '0;
               else if (!store_q) rdata_d = load_val;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         lane_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         store_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         store_q <= store_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Array is never reset; reset only cancels the write by leaving DONE.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) mem_q[idx_q][8*i +: 8] <= wlanes[8*i +: 8];
      end
   end

   always_comb begin
      mem_ready = (state_q == DONE);
      mem_err   = (state_q == DONE) & err_q;
      dReadData = rdata_q;
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed table, reset/latency sequences and random
// traffic compared against a byte-array reference model.
module tb_data_mem_unit;

   localparam logic [31:0] BASE = 32'h1001_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        mr [2];
   logic        mw [2];
   logic [31:0] ad [2];
   logic [31:0] wd [2];
   logic [31:0] rd [2];
   logic [2:0]  fn [2];
   logic        rdy [2];
   logic        er [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   data_mem_unit #(.BASE_ADDR(BASE), .ADDR_WIDTH(10), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .dAddress(ad[0]),
      .dWriteData(wd[0]), .funct3(fn[0]), .dReadData(rd[0]), .mem_ready(rdy[0]),
      .mem_err(er[0]));

   data_mem_unit #(.BASE_ADDR(BASE), .ADDR_WIDTH(10), .LATENCY(1)) dut_l1 (
      .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .dAddress(ad[1]),
      .dWriteData(wd[1]), .funct3(fn[1]), .dReadData(rd[1]), .mem_ready(rdy[1]),
      .mem_err(er[1]));

   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] a;
      logic [31:0] wdata;
      logic [2:0]  f;
      logic        exp_err;
      logic [31:0] exp_data;
   } vec_t;

   vec_t        tbl [$];
   logic [7:0]  ref_mem [4096];
   logic [31:0] ref_rd;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: byte-addressed memory, size from funct3, arithmetic sign extension.
   task automatic model(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wdata, input logic [2:0] f,
                        output logic e, output logic [31:0] d);
      int unsigned size;
      logic [31:0] off;
      logic [31:0] v;
      off  = a - BASE;
      size = 1 << f[1:0];
      e = (r && w) || (r && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
          || (w && !(f inside {3'd0, 3'd1, 3'd2})) || ((a % size) != 0) || (off >= 4096);
      if (e) begin
         ref_rd = '0;
      end else if (w) begin
         for (int unsigned i = 0; i < size; i++) begin
            v = wdata >> (8 * i);
            ref_mem[off + i] = v[7:0];
         end
      end else begin
         v = '0;
         for (int unsigned i = 0; i < size; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
         if (!f[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
         ref_rd = v;
      end
      d = ref_rd;
   endtask

   task automatic txn(input int d, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] wdata, input logic [2:0] f,
                      output logic e, output logic [31:0] q, output int lat);
      @(negedge clk);
      mr[d] = r; mw[d] = w; ad[d] = a; wd[d] = wdata; fn[d] = f;
      @(posedge clk);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (rdy[d]) begin
            lat = i;
            break;
         end
      end
      mr[d] = 1'b0; mw[d] = 1'b0;
      e = er[d];
      q = rd[d];
      @(posedge clk);
      #1;
      chk("ready_pulse_width", 32'(rdy[d]), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      logic        e, me;
      logic [31:0] q, md, a, wdata;
      logic [2:0]  f;
      logic        r, w;
      int          lat, pulses;

      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = '0; wd[d] = '0; fn[d] = '0;
      end
      ref_rd = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_ready%0d", d), 32'(rdy[d]), 32'd0);
         chk($sformatf("reset_err%0d", d), 32'(er[d]), 32'd0);
         chk($sformatf("reset_data%0d", d), rd[d], 32'd0);
      end
      @(negedge clk);
      rst = 1'b1;

      tbl.push_back('{1'b0, 1'b1, BASE,         32'hDEADBEEF, 3'd2, 1'b0, 32'h0000_0000});
      tbl.push_back('{1'b1, 1'b0, BASE,         32'h0,        3'd2, 1'b0, 32'hDEADBEEF});
      tbl.push_back('{1'b0, 1'b1, BASE + 1,     32'hAAAAAA7F, 3'd0, 1'b0, 32'hDEADBEEF});
      tbl.push_back('{1'b1, 1'b0, BASE,         32'h0,        3'd2, 1'b0, 32'hDEAD7FEF});
      tbl.push_back('{1'b1, 1'b0, BASE + 3,     32'h0,        3'd0, 1'b0, 32'hFFFFFFDE});
      tbl.push_back('{1'b1, 1'b0, BASE + 3,     32'h0,        3'd4, 1'b0, 32'h000000DE});
      tbl.push_back('{1'b0, 1'b1, BASE + 2,     32'h55558001, 3'd1, 1'b0, 32'h000000DE});
      tbl.push_back('{1'b1, 1'b0, BASE + 2,     32'h0,        3'd1, 1'b0, 32'hFFFF8001});
      tbl.push_back('{1'b1, 1'b0, BASE + 2,     32'h0,        3'd5, 1'b0, 32'h00008001});
      tbl.push_back('{1'b1, 1'b0, BASE + 2,     32'h0,        3'd2, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 1'b1, BASE + 1,     32'h00001234, 3'd1, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 1'b0, BASE + 4096,  32'h0,        3'd2, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 1'b0, BASE,         32'h0,        3'd2, 1'b0, 32'h80017FEF});
      tbl.push_back('{1'b0, 1'b1, BASE,         32'h0,        3'd4, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 1'b0, BASE,         32'h0,        3'd3, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 1'b0, BASE - 4,     32'h0,        3'd2, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 1'b1, BASE + 4092,  32'h0BADCAFE, 3'd2, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 1'b0, BASE + 4092,  32'h0,        3'd2, 1'b0, 32'h0BADCAFE});
      tbl.push_back('{1'b1, 1'b0, BASE + 4094,  32'h0,        3'd1, 1'b0, 32'h00000BAD});
      tbl.push_back('{1'b1, 1'b1, BASE,         32'h0,        3'd2, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 1'b0, BASE + 1,     32'h0,        3'd4, 1'b0, 32'h0000007F});
      tbl.push_back('{1'b1, 1'b0, BASE + 3,     32'h0,        3'd0, 1'b0, 32'hFFFFFF80});

      foreach (tbl[i]) begin
         txn(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wdata, tbl[i].f, e, q, lat);
         model(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wdata, tbl[i].f, me, md);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
         chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
         chk($sformatf("vec%0d_data", i), q, tbl[i].exp_data);
      end

      // Reset while a store is in flight: outputs clear, old word survives.
      txn(0, 1'b0, 1'b1, BASE + 8, 32'hCAFEF00D, 3'd2, e, q, lat);
      model(1'b0, 1'b1, BASE + 8, 32'hCAFEF00D, 3'd2, me, md);
      @(negedge clk);
      mr[0] = 1'b0; mw[0] = 1'b1; ad[0] = BASE + 8; wd[0] = 32'h12345678; fn[0] = 3'd2;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mw[0] = 1'b0;
      #1;
      chk("inflight_reset_ready", 32'(rdy[0]), 32'd0);
      chk("inflight_reset_err", 32'(er[0]), 32'd0);
      chk("inflight_reset_data", rd[0], 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      ref_rd = '0;
      txn(0, 1'b1, 1'b0, BASE + 8, 32'h0, 3'd2, e, q, lat);
      model(1'b1, 1'b0, BASE + 8, 32'h0, 3'd2, me, md);
      chk("dropped_store_data", q, 32'hCAFEF00D);
      chk("dropped_store_latency", 32'(lat), 32'd2);

      for (int i = 0; i < 16; i++) begin
         wdata = $urandom;
         txn(0, 1'b0, 1'b1, BASE + 32'(4 * i), wdata, 3'd2, e, q, lat);
         model(1'b0, 1'b1, BASE + 32'(4 * i), wdata, 3'd2, me, md);
         chk($sformatf("init%0d_err", i), 32'(e), 32'd0);
      end

      for (int i = 0; i < 250; i++) begin
         case ($urandom_range(0, 9))
            0:       a = BASE + 4092 + $urandom_range(0, 3);
            1:       a = BASE + 4096 + $urandom_range(0, 15);
            2:       a = BASE - $urandom_range(1, 8);
            default: a = BASE + $urandom_range(0, 63);
         endcase
         case ($urandom_range(0, 19))
            0:       begin r = 1'b1; w = 1'b1; end
            1, 2, 3, 4, 5, 6, 7, 8, 9:
                     begin r = 1'b1; w = 1'b0; end
            default: begin r = 1'b0; w = 1'b1; end
         endcase
         f     = 3'($urandom_range(0, 7));
         wdata = $urandom;
         txn(0, r, w, a, wdata, f, e, q, lat);
         model(r, w, a, wdata, f, me, md);
         chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd2);
         chk($sformatf("rnd%0d_err a=%h f=%0d r=%0b w=%0b", i, a, f, r, w), 32'(e), 32'(me));
         chk($sformatf("rnd%0d_data a=%h f=%0d r=%0b w=%0b", i, a, f, r, w), q, md);
      end

      // Single-cycle latency instance.
      txn(1, 1'b0, 1'b1, BASE + 16, 32'hA5A55A5A, 3'd2, e, q, lat);
      chk("l1_store_latency", 32'(lat), 32'd1);
      chk("l1_store_err", 32'(e), 32'd0);
      @(negedge clk);
      mr[1] = 1'b1; mw[1] = 1'b0; ad[1] = BASE + 16; fn[1] = 3'd2;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("l1_held_ready", 32'(rdy[1]), 32'd1);
      chk("l1_held_data", rd[1], 32'hA5A55A5A);
      @(posedge clk);
      #1;
      chk("l1_held_ready_drop", 32'(rdy[1]), 32'd0);
      mr[1] = 1'b0;
      pulses = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (rdy[1]) pulses++;
      end
      chk("l1_extra_pulses", 32'(pulses), 32'd0);
      txn(1, 1'b1, 1'b1, BASE + 16, 32'h0, 3'd2, e, q, lat);
      chk("l1_both_latency", 32'(lat), 32'd1);
      chk("l1_both_err", 32'(e), 32'd1);
      chk("l1_both_data", q, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
